nes_pad_poller: RTL and testbench
=================================

# nes_pad_poller

Sequences the shared NES pad bus for two controllers on one latch/clock pair, with a separate data line per pad. Polls both pads once per frame tick or on demand, synchronizes and deserializes the data, and presents stable, active-high button vectors with a one-cycle valid strobe. Game logic consumes its outputs, and it directly drives the pad connector pins.

## Interface
- `CLK_DIV`, default 256: clk48 cycles per half NES bit period; one pad bit = 2*CLK_DIV cycles.
- `FRAME_CYCLES`, default 1048576: cycles between automatic poll ticks; must exceed 18*CLK_DIV+2.
- `clk48`, in, 1: system clock, 48 MHz.
- `rst`, in, 1: **reset is asynchronous and active-high.**
- `poll_req`, in, 1: single-cycle request for an immediate extra poll.
- `pad_data`, in, 2: serial data from pad 1 (bit 0) and pad 2 (bit 1); active-low, asynchronous.
- `pad_latch`, out, 1: shared latch line.
- `pad_clock`, out, 1: shared shift clock line.
- `buttons_p1`, out, 8: held state of pad 1; 1 = pressed; [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `buttons_p2`, out, 8: same layout for pad 2.
- `pressed_p1`, out, 8: newly pressed buttons for pad 1, pulsed with `valid`.
- `pressed_p2`, out, 8: newly pressed buttons for pad 2, pulsed with `valid`.
- `valid`, out, 1: one-cycle strobe when new button vectors are committed.
- `busy`, out, 1: high while a poll is in progress, i.e. any state other than IDLE.

## Operation
- Each `pad_data` bit passes through a 2-FF synchronizer before use.
- Free-running frame counter counts 0..FRAME_CYCLES-1 and produces `tick` on wrap. The counter is unaffected by polling.
- A single `pending` bit is set by `tick` or `poll_req`. It is cleared when IDLE launches a poll. Simultaneous or repeated sources coalesce into one poll.
- FSM states:
  - IDLE: lines low. If `pending`, go to LATCH.
  - LATCH: `pad_latch`=1 for 2*CLK_DIV cycles, then go to SHIFT with bit index 0.
  - SHIFT: 8 bit periods. In each, `pad_clock`=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV cycles. Sample both synchronized data bits on the last low cycle. Shift the inverted sample into the LSB of the per-pad shift register. After bit 7's high half, go to DONE.
  - DONE: one cycle. Copy the shift registers to `buttons_pN`, assert `valid`, then go to IDLE.
- Requests that arrive while `busy` set `pending` and are served immediately after DONE.
- Outputs change only in DONE; between polls they hold their values.

## Timing
- Reset values: all outputs are 0, FSM is in IDLE, counters and `pending` are 0.
- Reset asserted mid-poll aborts immediately. Lines go low, held vectors clear, and no `valid` is produced.
- Poll length: 18*CLK_DIV cycles of LATCH+SHIFT, plus one DONE cycle. `valid` is asserted in cycle 18*CLK_DIV+1, counting the LATCH entry cycle as 0.
- Latency from `poll_req` in IDLE to the first `pad_latch`=1 cycle: 2 cycles (capture `pending`, then transition).
- Input synchronizer latency is 2 cycles. Pads must hold data at least 3 cycles before the sample point; with CLK_DIV≥4 this is met.
- Bit counter is 3 bits, phase counter is ceil(log2(2*CLK_DIV)) bits, and the frame counter wraps to 0 with no overflow.

## Configuration
- `NES_PAD_EDGE_EN` defined: `pressed_pN` = new & ~previous held vector, valid only in the `valid` cycle and 0 otherwise. The first poll after reset treats the previous vector as 0.
- Not defined: `pressed_pN` are tied to 0 and the edge logic is absent.

## Structure
- Package `nes_pkg`:
  - `NES_BITS`=8.
  - Button index constants `BTN_A`..`BTN_RIGHT`.
  - FSM state enum `nes_state_t` (IDLE, LATCH, SHIFT, DONE).
- Sub-module `nes_pad_lane`, instantiated twice, contains:
  - the 2-FF synchronizer;
  - the 8-bit shift register;
  - the held register;
  - the optional edge detect.
  - It is driven by `sample_en` and `commit_en` from the top-level FSM.

## Test plan
- Simulation parameters: CLK_DIV=4, FRAME_CYCLES=200.
- Reset: after reset release, outputs are 0 and `busy`=0. The first `pad_latch` rises at cycle 200+1 and stays high for 8 cycles.
- Pad 1 serial pattern A,Start,Right pressed (`pad_data[0]` low on bits 0,3,7), pad 2 idle high -> `buttons_p1`=8'b1001_0001 and `buttons_p2`=0, with `valid` at cycle 73 of the poll.
- `poll_req` in IDLE -> latch after 2 cycles. A second `poll_req` plus a `tick` during that poll -> exactly one extra poll, started directly after DONE.
- Reset asserted during SHIFT bit 4 -> lines low next cycle, held vectors 0, no `valid`. The next poll completes normally.
- With `NES_PAD_EDGE_EN`, poll 1 gives A pressed and poll 2 gives A+B -> `pressed_p1` = 8'h80, then 8'h40, each only in its `valid` cycle. Without the macro, `pressed_p1` stays 0.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared constants and types for the NES pad poller.
package nes_pkg;

  localparam int NES_BITS = 8;

  // Bit positions in the held/pressed button vectors.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_t;

endpackage

// File: rtl/nes_pad_lane.sv
// One pad data lane: input synchronizer, deserializer, held vector and
// optional new-press detection (enabled by NES_PAD_EDGE_EN).
module nes_pad_lane
  import nes_pkg::*;
(
  input  logic                clk48,
  input  logic                rst,
  input  logic                pad_data_n,
  input  logic                sample_en,
  input  logic                commit_en,
  output logic [NES_BITS-1:0] buttons,
  output logic [NES_BITS-1:0] pressed
);

  logic [1:0]          sync_q, sync_d;
  logic [NES_BITS-1:0] shift_q, shift_d;
  logic [NES_BITS-1:0] held_q, held_d;

  // Serial bit 0 (A) ends up in the MSB after eight shifts.
  always_comb begin
    sync_d = {sync_q[0], pad_data_n};
    if (sample_en) begin
      shift_d = {shift_q[NES_BITS-2:0], ~sync_q[1]};
    end else begin
      shift_d = shift_q;
    end
    if (commit_en) begin
      held_d = shift_q;
    end else begin
      held_d = held_q;
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      shift_q <= {NES_BITS{1'b0}};
      held_q  <= {NES_BITS{1'b0}};
    end else begin
      sync_q  <= sync_d;
      shift_q <= shift_d;
      held_q  <= held_d;
    end
  end

  assign buttons = held_q;

`ifdef NES_PAD_EDGE_EN
  logic [NES_BITS-1:0] pressed_q, pressed_d;

  always_comb begin
    if (commit_en) begin
      pressed_d = shift_q & ~held_q;
    end else begin
      pressed_d = {NES_BITS{1'b0}};
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      pressed_q <= {NES_BITS{1'b0}};
    end else begin
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;
`else
  assign pressed = {NES_BITS{1'b0}};
`endif

endmodule

// File: rtl/nes_pad_poller.sv
// Two-pad NES controller poller sharing one latch/clock pair.
// Define NES_PAD_EDGE_EN to enable the pressed_pN new-press outputs.
module nes_pad_poller
  import nes_pkg::*;
#(
  parameter int CLK_DIV      = 256,
  parameter int FRAME_CYCLES = 1048576
) (
  input  logic                clk48,
  input  logic                rst,
  input  logic                poll_req,
  input  logic [1:0]          pad_data,
  output logic                pad_latch,
  output logic                pad_clock,
  output logic [NES_BITS-1:0] buttons_p1,
  output logic [NES_BITS-1:0] buttons_p2,
  output logic [NES_BITS-1:0] pressed_p1,
  output logic [NES_BITS-1:0] pressed_p2,
  output logic                valid,
  output logic                busy
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH   = PW'(CLK_DIV);
  localparam logic [FW-1:0] FR_LAST   = FW'(FRAME_CYCLES - 1);

  nes_state_t    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          pending_q, pending_d;
  logic          pad_latch_q, pad_latch_d;
  logic          pad_clock_q, pad_clock_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          tick, launch, sample_en, commit_en;

  // Frame counter free-runs; every request source folds into one pending bit.
  always_comb begin
    tick   = (frame_q == FR_LAST);
    launch = (state_q == IDLE) && pending_q;
    if (tick) begin
      frame_d = {FW{1'b0}};
    end else begin
      frame_d = frame_q + FW'(1);
    end
    if (launch) begin
      pending_d = tick | poll_req;
    end else begin
      pending_d = pending_q | tick | poll_req;
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= {PW{1'b0}};
      bit_q       <= 3'd0;
      frame_q     <= {FW{1'b0}};
      pending_q   <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clock_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      pending_q   <= pending_d;
      pad_latch_q <= pad_latch_d;
      pad_clock_q <= pad_clock_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        phase_d = {PW{1'b0}};
        bit_d   = 3'd0;
        if (pending_q) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        if (phase_q == PH_LAST) begin
          state_d = SHIFT;
          phase_d = {PW{1'b0}};
          bit_d   = 3'd0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = {PW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line levels are derived from the next state so the pins are registered
  // yet stay aligned with the state they belong to.
  always_comb begin
    pad_latch_d = (state_d == LATCH);
    pad_clock_d = (state_d == SHIFT) && (phase_d >= PH_HIGH);
    busy_d      = (state_d != IDLE);
    valid_d     = (state_q == DONE);
    sample_en   = (state_q == SHIFT) && (phase_q == PH_SAMPLE);
    commit_en   = (state_q == DONE);
  end

  nes_pad_lane u_lane_p1 (
    .clk48      (clk48),
    .rst        (rst),
    .pad_data_n (pad_data[0]),
    .sample_en  (sample_en),
    .commit_en  (commit_en),
    .buttons    (buttons_p1),
    .pressed    (pressed_p1)
  );

  nes_pad_lane u_lane_p2 (
    .clk48      (clk48),
    .rst        (rst),
    .pad_data_n (pad_data[1]),
    .sample_en  (sample_en),
    .commit_en  (commit_en),
    .buttons    (buttons_p2),
    .pressed    (pressed_p2)
  );

  assign pad_latch = pad_latch_q;
  assign pad_clock = pad_clock_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Scoreboard bench for nes_pad_poller with a behavioural pair of NES pads.
module tb_nes_pad_poller;

  localparam int CLK_DIV      = 4;
  localparam int FRAME_CYCLES = 200;

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic       poll_req = 1'b0;
  logic [1:0] pad_data;
  logic       pad_latch, pad_clock, valid, busy;
  logic [7:0] buttons_p1, buttons_p2, pressed_p1, pressed_p2;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_latch = 0;
  int n_valid = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;

  // mask bit i set = pad pulls its line low at serial position i
  logic [7:0] mask1 = 8'h00, mask2 = 8'h00;
  logic [7:0] cur_b1 = 8'h00, cur_b2 = 8'h00;
  logic [3:0] pidx = 4'd8;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk48 = ~clk48;

  nes_pad_poller #(.CLK_DIV(CLK_DIV), .FRAME_CYCLES(FRAME_CYCLES)) dut (
    .clk48      (clk48),
    .rst        (rst),
    .poll_req   (poll_req),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clock  (pad_clock),
    .buttons_p1 (buttons_p1),
    .buttons_p2 (buttons_p2),
    .pressed_p1 (pressed_p1),
    .pressed_p2 (pressed_p2),
    .valid      (valid),
    .busy       (busy)
  );

  always @(posedge clk48) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // 4021-style pad: latch reloads, each rising clock advances one bit.
  always @(posedge pad_clock or posedge pad_latch) begin
    if (pad_latch)          pidx <= 4'd0;
    else if (pidx != 4'd8)  pidx <= pidx + 4'd1;
    else                    pidx <= pidx;
  end
  assign pad_data[0] = (pidx < 4'd8) ? ~mask1[pidx[2:0]] : 1'b1;
  assign pad_data[1] = (pidx < 4'd8) ? ~mask2[pidx[2:0]] : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk48);
    #1;
  endtask

  task automatic step_until(input int c);
    int k = 0;
    while (cyc < c && k < 2000) begin
      step();
      k++;
    end
  endtask

  task automatic set_pattern(input logic [7:0] m1, input logic [7:0] m2,
                             input logic [7:0] b1, input logic [7:0] b2);
    mask1 = m1; mask2 = m2; cur_b1 = b1; cur_b2 = b2;
  endtask

  task automatic pulse_req();
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
  endtask

  task automatic wait_latch(input int budget, input string what);
    int start = n_latch;
    int k = 0;
    while (n_latch == start && k < budget) begin
      step();
      k++;
    end
    if (n_latch == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no pad_latch rise within %0d cycles", what, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string what);
    int start = n_valid;
    int k = 0;
    while (n_valid == start && k < budget) begin
      step();
      k++;
    end
    if (n_valid == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no valid within %0d cycles", what, budget);
    end
  endtask

  // Monitor: queue an expectation per launched poll, compare at each valid.
  initial begin
    exp_t       e;
    logic [7:0] prev1, prev2, epr1, epr2;
    logic       latch_prev;
    prev1 = 8'h00; prev2 = 8'h00; latch_prev = 1'b0;
    forever begin
      @(negedge clk48);
      if (rst) begin
        exp_q.delete();
        prev1 = 8'h00;
        prev2 = 8'h00;
        latch_prev = 1'b0;
      end else begin
        if (pad_latch && !latch_prev) begin
          n_latch++;
          rise_cyc = cyc;
          exp_q.push_back('{b1: cur_b1, b2: cur_b2});
        end
        latch_prev = pad_latch;
        if (valid) begin
          n_valid++;
          valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_unexpected: valid at cycle %0d with no poll outstanding", cyc);
          end else begin
            e = exp_q.pop_front();
`ifdef NES_PAD_EDGE_EN
            epr1 = e.b1 & ~prev1;
            epr2 = e.b2 & ~prev2;
`else
            epr1 = 8'h00;
            epr2 = 8'h00;
`endif
            check("buttons_p1", buttons_p1, e.b1);
            check("buttons_p2", buttons_p2, e.b2);
            check("pressed_p1", pressed_p1, epr1);
            check("pressed_p2", pressed_p2, epr2);
            prev1 = e.b1;
            prev2 = e.b2;
          end
        end else begin
          check("pressed_outside_valid", {pressed_p1, pressed_p2}, 16'h0000);
        end
      end
    end
  end

  initial begin
    int c, r, v, nl, vb, len;

    // Reset and the first frame-tick poll: A, Start, Right on pad 1.
    set_pattern(8'b1000_1001, 8'b0000_0000, 8'b1001_0001, 8'b0000_0000);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_buttons", {buttons_p1, buttons_p2}, 16'h0000);
    check("reset_lines", {pad_latch, pad_clock, valid, busy}, 4'b0000);
    wait_latch(300, "tick_poll");
    check("first_latch_cycle", rise_cyc, FRAME_CYCLES + 1);
    check("busy_in_poll", busy, 1'b1);
    len = 0;
    while (pad_latch && len < 50) begin
      len++;
      step();
    end
    check("latch_width", len, 2 * CLK_DIV);
    wait_valid(100, "tick_poll_valid");
    check("valid_offset", valid_cyc - rise_cyc, 18 * CLK_DIV + 1);

    // On-demand poll: B+Select on pad 1, Up+Left on pad 2.
    set_pattern(8'b0000_0110, 8'b0101_0000, 8'b0110_0000, 8'b0000_1010);
    step_until(300);
    c = cyc;
    pulse_req();
    wait_latch(10, "req_poll");
    check("req_latency", rise_cyc - c, 2);
    wait_valid(100, "req_poll_valid");

    // A tick and a second request during a poll coalesce into one extra poll.
    step_until(380);
    c = cyc;
    pulse_req();
    wait_latch(10, "coalesce_poll");
    check("req_latency_2", rise_cyc - c, 2);
    step_until(420);
    pulse_req();
    wait_valid(100, "coalesce_first_valid");
    v = valid_cyc;
    nl = n_latch;
    wait_latch(5, "coalesce_extra");
    check("extra_poll_start", rise_cyc - v, 1);
    wait_valid(100, "coalesce_extra_valid");
    step_until(595);
    check("extra_poll_count", n_latch - nl, 1);

    // Abort the next tick poll during the high half of bit 4.
    wait_latch(20, "abort_poll");
    r = rise_cyc;
    step_until(r + 8 + 4 * 2 * CLK_DIV + CLK_DIV + 1);
    check("clock_high_bit4", pad_clock, 1'b1);
    vb = n_valid;
    rst = 1'b1;
    step();
    check("abort_lines", {pad_latch, pad_clock, valid, busy}, 4'b0000);
    check("abort_buttons", {buttons_p1, buttons_p2}, 16'h0000);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("abort_no_valid", n_valid - vb, 0);

    // New-press detection: A, then A+B.
    set_pattern(8'b0000_0001, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000);
    pulse_req();
    wait_latch(10, "edge_poll_1");
    wait_valid(100, "edge_poll_1_valid");
    set_pattern(8'b0000_0011, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);
    pulse_req();
    wait_latch(10, "edge_poll_2");
    wait_valid(100, "edge_poll_2_valid");
    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
